slave_rx_port: RTL and testbench

Parametrised serial receive port for a bus slave. It accepts a transaction from the master on a `master_valid`/`slave_ready` handshake, then shifts in an LSB-first serial address and, for writes, a serial data word. It presents both as parallel words to the slave's memory/register logic, and holds them until that logic acknowledges. It replaces the fixed 12/8-bit slave input port; all logic is fully synchronous to `clk`, and the handshake is sampled rather than used as a clock.

---
 rtl/slave_bus_pkg.sv | 23 ++
 rtl/serial_capture.sv | 41 ++++
 rtl/slave_rx_port.sv | 120 ++++++++++++
 tb/tb_slave_rx_port.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/slave_bus_pkg.sv
// Shared types and constants for the serial slave bus receive path.
// State encoding, default field widths, transfer mode and a width helper.
package slave_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } mode_t;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_capture.sv
// Shadow register that loads serial_in into the bit selected by bit_idx while en is high.
// Indices at or beyond WIDTH match no bit and are silently dropped.
module serial_capture
    import slave_bus_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [IDX_W-1:0] bit_idx,
    input  logic             serial_in,
    output logic [WIDTH-1:0] shadow
);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_shadow_nxt;

    always_comb begin
        w_shadow_nxt = r_shadow;
        if (en) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (bit_idx == IDX_W'(k)) begin
                    w_shadow_nxt[k] = serial_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow <= '0;
        end else begin
            r_shadow <= w_shadow_nxt;
        end
    end

    assign shadow = r_shadow;

endmodule

// File: rtl/slave_rx_port.sv
// Serial receive port: handshake, LSB-first address/data shift-in, parallel
// presentation of the completed frame held until the downstream acknowledges.
module slave_rx_port
    import slave_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  master_valid,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic                  rx_address,
    input  logic                  rx_data,
    input  logic                  rx_ack,
    output logic                  slave_ready,
    output logic                  rx_done,
    output logic                  rx_write,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int MAX_W = max_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_W = $clog2(MAX_W + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    mode_t                 r_mode;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_start;
    logic                  w_recv;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_addr_shadow;
    logic [DATA_WIDTH-1:0] w_data_shadow;
    logic [ADDR_WIDTH-1:0] w_addr_final;
    logic [DATA_WIDTH-1:0] w_data_final;

    // Handshake without either enable is dropped: the FSM simply stays idle.
    assign w_start = (r_state == ST_IDLE) && master_valid && (write_en || read_en);
    assign w_recv  = (r_state == ST_RECV);
    assign w_last  = w_recv && ((r_mode == MODE_WRITE) ? (r_cnt == CNT_W'(MAX_W - 1))
                                                       : (r_cnt == CNT_W'(ADDR_WIDTH - 1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_RECV;
            ST_RECV: if (w_last)  w_state_nxt = ST_HOLD;
            ST_HOLD: if (rx_ack)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_mode <= MODE_READ;
        end else if (w_start) begin
            r_cnt  <= '0;
            r_mode <= write_en ? MODE_WRITE : MODE_READ;
        end else if (w_recv) begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    serial_capture #(.WIDTH(ADDR_WIDTH), .IDX_W(CNT_W)) u_addr_cap (
        .clk       (clk),
        .reset     (reset),
        .en        (w_recv),
        .bit_idx   (r_cnt),
        .serial_in (rx_address),
        .shadow    (w_addr_shadow)
    );

    serial_capture #(.WIDTH(DATA_WIDTH), .IDX_W(CNT_W)) u_data_cap (
        .clk       (clk),
        .reset     (reset),
        .en        (w_recv && (r_mode == MODE_WRITE)),
        .bit_idx   (r_cnt),
        .serial_in (rx_data),
        .shadow    (w_data_shadow)
    );

    // The top bit of a field may land on the completion edge itself, so it is
    // merged here rather than waiting a cycle for the shadow to catch up.
    always_comb begin
        w_addr_final = w_addr_shadow;
        w_data_final = w_data_shadow;
        if (r_cnt == CNT_W'(ADDR_WIDTH - 1)) w_addr_final[ADDR_WIDTH-1] = rx_address;
        if (r_cnt == CNT_W'(DATA_WIDTH - 1)) w_data_final[DATA_WIDTH-1] = rx_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done  <= 1'b0;
            rx_write <= 1'b0;
            address  <= '0;
            data     <= '0;
        end else begin
            rx_done <= w_last;
            if (w_last) begin
                address  <= w_addr_final;
                rx_write <= (r_mode == MODE_WRITE);
                if (r_mode == MODE_WRITE) data <= w_data_final;
            end
        end
    end

    assign slave_ready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_slave_rx_port.sv
// Bench for slave_rx_port: a default 12/8 instance and an 8/16 instance, driven
// with directed frames; outputs compared every cycle against a frame-level model.
module tb_slave_rx_port;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic mv[2], we[2], rd[2], rxa[2], rxd[2], ack[2];
    logic o_rdy[2], o_done[2], o_wr[2];
    logic [31:0] o_addr[2], o_data[2];

    logic [11:0] a_addr;
    logic [7:0]  a_data;
    logic [7:0]  b_addr;
    logic [15:0] b_data;

    slave_rx_port dut_a (
        .clk(clk), .reset(reset), .master_valid(mv[0]), .write_en(we[0]), .read_en(rd[0]),
        .rx_address(rxa[0]), .rx_data(rxd[0]), .rx_ack(ack[0]), .slave_ready(o_rdy[0]),
        .rx_done(o_done[0]), .rx_write(o_wr[0]), .address(a_addr), .data(a_data)
    );

    slave_rx_port #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut_b (
        .clk(clk), .reset(reset), .master_valid(mv[1]), .write_en(we[1]), .read_en(rd[1]),
        .rx_address(rxa[1]), .rx_data(rxd[1]), .rx_ack(ack[1]), .slave_ready(o_rdy[1]),
        .rx_done(o_done[1]), .rx_write(o_wr[1]), .address(b_addr), .data(b_data)
    );

    assign o_addr[0] = 32'(a_addr);
    assign o_data[0] = 32'(a_data);
    assign o_addr[1] = 32'(b_addr);
    assign o_data[1] = 32'(b_data);

    int aw[2];
    int dw[2];
    logic        exp_rdy[2], exp_done[2], exp_wr[2];
    logic [31:0] exp_addr[2], exp_data[2];
    int done_cnt[2];
    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    function automatic logic [31:0] field_mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    task automatic check(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, u, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            exp_rdy[u] = 1'b1; exp_done[u] = 1'b0; exp_wr[u] = 1'b0;
            exp_addr[u] = '0; exp_data[u] = '0;
        end
    endtask

    // Per-cycle comparison, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                check("slave_ready", u, 32'(o_rdy[u]), 32'(exp_rdy[u]));
                check("rx_done",     u, 32'(o_done[u]), 32'(exp_done[u]));
                check("rx_write",    u, 32'(o_wr[u]), 32'(exp_wr[u]));
                check("address",     u, o_addr[u], exp_addr[u]);
                check("data",        u, o_data[u], exp_data[u]);
                if (o_done[u] === 1'b1) done_cnt[u]++;
            end
        end
    end

    // One transaction starting in IDLE just after an edge. ack_wait = extra HOLD
    // cycles before acking; abort_at = edge index after T0 at which reset is pulsed.
    task automatic run_frame(input int u, input bit wr, input bit rdi, input logic [31:0] a,
                             input logic [31:0] d, input int ack_wait, input bit ack_hold,
                             input bit toggle, input int abort_at);
        int n;
        bit ack_now;
        mv[u] = 1'b1; we[u] = wr; rd[u] = rdi;
        if (ack_hold) ack[u] = 1'b1;
        @(posedge clk); #1;
        mv[u] = 1'b0; we[u] = 1'b0; rd[u] = 1'b0;
        if (!wr && !rdi) return;
        exp_rdy[u] = 1'b0;
        n = wr ? ((aw[u] > dw[u]) ? aw[u] : dw[u]) : aw[u];
        for (int i = 0; i < n; i++) begin
            rxa[u] = a[i];
            rxd[u] = d[i];
            if (toggle) begin
                mv[u] = i[0];
                we[u] = 1'($urandom_range(0, 1));
                rd[u] = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            if (abort_at == i + 1) begin
                reset = 1'b0;
                #1;
                check("rst_ready", u, 32'(o_rdy[u]), 32'h1);
                check("rst_done",  u, 32'(o_done[u]), 32'h0);
                check("rst_write", u, 32'(o_wr[u]), 32'h0);
                check("rst_addr",  u, o_addr[u], 32'h0);
                check("rst_data",  u, o_data[u], 32'h0);
                model_reset();
                mv[u] = 1'b0; we[u] = 1'b0; rd[u] = 1'b0;
                #1 reset = 1'b1;
                @(posedge clk); #1;
                return;
            end
        end
        mv[u] = 1'b0; we[u] = 1'b0; rd[u] = 1'b0;
        exp_addr[u] = a & field_mask(aw[u]);
        if (wr) exp_data[u] = d & field_mask(dw[u]);
        exp_wr[u] = wr;
        exp_done[u] = 1'b1;
        ack_now = ack_hold || (ack_wait == 0);
        ack[u] = ack_now;
        @(posedge clk); #1;
        exp_done[u] = 1'b0;
        if (!ack_now) begin
            repeat (ack_wait - 1) begin @(posedge clk); #1; end
            ack[u] = 1'b1;
            @(posedge clk); #1;
        end
        exp_rdy[u] = 1'b1;
        if (!ack_hold) ack[u] = 1'b0;
    endtask

    initial begin
        aw[0] = 12; dw[0] = 8;
        aw[1] = 8;  dw[1] = 16;
        for (int u = 0; u < 2; u++) begin
            mv[u] = 0; we[u] = 0; rd[u] = 0; rxa[u] = 0; rxd[u] = 0; ack[u] = 0;
            done_cnt[u] = 0;
        end
        model_reset();
        #22;
        check("init_ready", 0, 32'(o_rdy[0]), 32'h1);
        check("init_addr",  0, o_addr[0], 32'h0);
        check("init_data",  1, o_data[1], 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Default widths: write then read.
        run_frame(0, 1'b1, 1'b0, 32'hA5C, 32'h3B, 2, 1'b0, 1'b0, 0);
        check("w_addr_lit", 0, o_addr[0], 32'hA5C);
        check("w_data_lit", 0, o_data[0], 32'h3B);
        check("w_wr_lit",   0, 32'(o_wr[0]), 32'h1);
        run_frame(0, 1'b0, 1'b1, 32'h123, 32'hFF, 0, 1'b0, 1'b0, 0);
        check("r_addr_lit", 0, o_addr[0], 32'h123);
        check("r_data_lit", 0, o_data[0], 32'h3B);
        check("r_wr_lit",   0, 32'(o_wr[0]), 32'h0);

        // Handshake with no enable is ignored.
        run_frame(0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 0);
        check("none_ready", 0, 32'(o_rdy[0]), 32'h1);
        repeat (2) begin @(posedge clk); #1; end

        // Both enables (write wins), master inputs churning mid-frame, late ack.
        run_frame(0, 1'b1, 1'b1, 32'h5A3, 32'hC7, 3, 1'b0, 1'b1, 0);
        check("tog_addr_lit", 0, o_addr[0], 32'h5A3);
        check("tog_data_lit", 0, o_data[0], 32'hC7);

        // Reset pulse at T0+5, then a clean frame.
        run_frame(0, 1'b1, 1'b0, 32'hFFF, 32'hFF, 0, 1'b0, 1'b0, 5);
        run_frame(0, 1'b1, 1'b0, 32'h001, 32'h80, 1, 1'b0, 1'b0, 0);
        check("post_rst_addr", 0, o_addr[0], 32'h001);
        check("post_rst_data", 0, o_data[0], 32'h80);

        // rx_ack held high: frames back to back, N+2 apart.
        run_frame(0, 1'b1, 1'b0, 32'h800, 32'h01, 0, 1'b1, 1'b0, 0);
        run_frame(0, 1'b0, 1'b1, 32'h7FF, 32'h00, 0, 1'b1, 1'b0, 0);
        run_frame(0, 1'b1, 1'b0, 32'h0F0, 32'hAA, 0, 1'b1, 1'b0, 0);
        ack[0] = 1'b0;
        check("b2b_addr_lit", 0, o_addr[0], 32'h0F0);
        check("b2b_data_lit", 0, o_data[0], 32'hAA);

        // 8-bit address / 16-bit data: upper serial address bits must be dropped.
        run_frame(1, 1'b1, 1'b0, 32'hA57F, 32'hBEEF, 0, 1'b0, 1'b0, 0);
        check("b_addr_lit", 1, o_addr[1], 32'h7F);
        check("b_data_lit", 1, o_data[1], 32'hBEEF);
        run_frame(1, 1'b0, 1'b1, 32'h42, 32'h1234, 1, 1'b0, 1'b0, 0);
        check("b_rd_addr_lit", 1, o_addr[1], 32'h42);
        check("b_rd_data_lit", 1, o_data[1], 32'hBEEF);

        repeat (3) begin @(posedge clk); #1; end
        chk_en = 1'b0;
        check("done_pulses_a", 0, 32'(done_cnt[0]), 32'd7);
        check("done_pulses_b", 1, 32'(done_cnt[1]), 32'd2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
